f1_start_sequencer: RTL and testbench

Controller for the F1 start-light bar. One trigger runs the whole start. It clears the light FSM and advances it one light per tick until all eight lights are lit. It then holds for a pseudo-random number of ticks and sends one more advance that turns all lights off ("go"). Finally it measures the driver's reaction time in clock cycles, or flags a false start. It sits between the board inputs (trigger and stop buttons) and the light-bar FSM's `rst`/`en` inputs.

---
 rtl/f1_start_sequencer.sv | 147 ++++++++++++++
 tb/tb_f1_start_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_sequencer.sv
// Start-light sequencer: lights the bar one lamp per tick, holds for an LFSR-chosen delay,
// releases "go" and times the driver's reaction (or flags a false start).
module f1_start_sequencer #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [6:0]  LFSR_SEED = 7'h01,
  parameter int unsigned REACT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic               stop,
  output logic               fsm_rst,
  output logic               fsm_en,
  output logic               busy,
  output logic               go,
  output logic [REACT_W-1:0] reaction_time,
  output logic               reaction_valid,
  output logic               false_start
);

  localparam int unsigned        TickW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0]   TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [REACT_W-1:0] ReactMax = '1;

  typedef enum logic [1:0] {StIdle, StLights, StHold, StGo} state_e;

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [2:0]           light_cnt_q, light_cnt_d;
  logic [6:0]           delay_cnt_q, delay_cnt_d;
  logic [6:0]           lfsr_q, lfsr_d;
  logic [REACT_W-1:0]   react_cnt_q, react_cnt_d;
  logic [REACT_W-1:0]   reaction_time_q, reaction_time_d;
  logic                 reaction_valid_q, reaction_valid_d;
  logic                 false_start_q, false_start_d;
  logic                 fsm_rst_q, fsm_rst_d;
  logic                 tick_wrap;
  logic                 tick;

  assign tick_wrap = (tick_cnt_q == TickMax);
  assign tick      = tick_wrap && ((state_q == StLights) || (state_q == StHold));

  // x^7 + x^3 + 1, maximal length, so a nonzero seed never reaches zero
  assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[2]};

  always_comb begin
    state_d          = state_q;
    tick_cnt_d       = tick_wrap ? '0 : tick_cnt_q + TickW'(1);
    light_cnt_d      = light_cnt_q;
    delay_cnt_d      = delay_cnt_q;
    react_cnt_d      = react_cnt_q;
    reaction_time_d  = reaction_time_q;
    reaction_valid_d = 1'b0;
    false_start_d    = 1'b0;
    fsm_rst_d        = 1'b0;
    fsm_en           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d     = StLights;
          light_cnt_d = '0;
          tick_cnt_d  = '0;
          fsm_rst_d   = 1'b1;
        end
      end

      StLights: begin
        fsm_en = tick;
        if (stop) begin
          state_d       = StIdle;
          false_start_d = 1'b1;
          fsm_rst_d     = 1'b1;
        end else if (tick) begin
          light_cnt_d = light_cnt_q + 3'd1;
          if (light_cnt_q == 3'd7) begin
            state_d     = StHold;
            delay_cnt_d = lfsr_q;
          end
        end
      end

      StHold: begin
        // fsm_en is decoded from state and counters only, keeping stop off the output path
        fsm_en = tick && (delay_cnt_q == 7'd1);
        if (stop) begin
          state_d       = StIdle;
          false_start_d = 1'b1;
          fsm_rst_d     = 1'b1;
        end else if (tick) begin
          delay_cnt_d = delay_cnt_q - 7'd1;
          if (delay_cnt_q == 7'd1) begin
            state_d     = StGo;
            react_cnt_d = '0;
          end
        end
      end

      StGo: begin
        if (react_cnt_q != ReactMax) begin
          react_cnt_d = react_cnt_q + REACT_W'(1);
        end
        if (stop) begin
          state_d          = StIdle;
          reaction_time_d  = react_cnt_q;
          reaction_valid_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      tick_cnt_q       <= '0;
      light_cnt_q      <= '0;
      delay_cnt_q      <= '0;
      lfsr_q           <= LFSR_SEED;
      react_cnt_q      <= '0;
      reaction_time_q  <= '0;
      reaction_valid_q <= 1'b0;
      false_start_q    <= 1'b0;
      fsm_rst_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      tick_cnt_q       <= tick_cnt_d;
      light_cnt_q      <= light_cnt_d;
      delay_cnt_q      <= delay_cnt_d;
      lfsr_q           <= lfsr_d;
      react_cnt_q      <= react_cnt_d;
      reaction_time_q  <= reaction_time_d;
      reaction_valid_q <= reaction_valid_d;
      false_start_q    <= false_start_d;
      fsm_rst_q        <= fsm_rst_d;
    end
  end

  assign fsm_rst        = fsm_rst_q;
  assign busy           = (state_q != StIdle);
  assign go             = (state_q == StGo);
  assign reaction_time  = reaction_time_q;
  assign reaction_valid = reaction_valid_q;
  assign false_start    = false_start_q;

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Randomised bench for f1_start_sequencer: a driver predicts every output pulse into a
// scoreboard queue; an independent monitor pops and compares whenever a pulse appears.
module tb_f1_start_sequencer;

  localparam int unsigned TD   = 4;
  localparam logic [6:0]  SEED = 7'h2B;
  localparam int unsigned RW   = 4;
  localparam int          RMAX = (1 << RW) - 1;

  localparam logic [3:0] VRst   = 4'b1000;  // {fsm_rst, fsm_en, false_start, reaction_valid}
  localparam logic [3:0] VEn    = 4'b0100;
  localparam logic [3:0] VFalse = 4'b1010;
  localparam logic [3:0] VReact = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trigger = 1'b0;
  logic          stop = 1'b0;
  logic          fsm_rst, fsm_en, busy, go, reaction_valid, false_start;
  logic [RW-1:0] reaction_time;

  f1_start_sequencer #(
    .TICK_DIV (TD),
    .LFSR_SEED(SEED),
    .REACT_W  (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger       (trigger),
    .stop          (stop),
    .fsm_rst       (fsm_rst),
    .fsm_en        (fsm_en),
    .busy          (busy),
    .go            (go),
    .reaction_time (reaction_time),
    .reaction_valid(reaction_valid),
    .false_start   (false_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cy;
    logic [3:0] vec;
    bit         chk_rt;
    int         rt;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_rt = 0;
  logic [6:0] m_lfsr;

  // Reference LFSR for x^7 + x^3 + 1: new bit = old bit 7 xor old bit 3, shifted in at the bottom
  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    int x, fb;
    x  = int'(v);
    fb = ((x / 64) + (x / 4)) % 2;
    return 7'((x * 2 + fb) % 128);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic void push(input int cy, input logic [3:0] vec, input bit chk, input int rt);
    ev_t e;
    e.cy = cy; e.vec = vec; e.chk_rt = chk; e.rt = rt;
    exp_q.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [3:0] vec;
    ev_t e;
    if (cyc > 0) begin
      vec = {fsm_rst, fsm_en, false_start, reaction_valid};
      if (vec != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(vec), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cy);
          check("pulse_kind", 32'(vec), 32'(e.vec));
          if (e.chk_rt) check("reaction_time", 32'(reaction_time), e.rt);
        end
      end
    end
  end

  // mode 0: normal start; 1: false start in LIGHTS; 2: false start on a HOLD tick;
  // 3: reset during LIGHTS after the third advance
  task automatic run(input int mode_in, input int force_n);
    int         c, d, g, s, n, mode;
    logic [6:0] v;
    mode = mode_in;
    @(negedge clk);
    c = cyc;
    trigger = 1'b1;
    v = m_lfsr;
    for (int i = 0; i < 8 * int'(TD); i++) v = lfsr_next(v);
    d = int'(v);
    if (mode == 2 && d < 2) mode = 1;
    g = c + (8 + d) * int'(TD) + 1;
    n = 0;
    push(c + 1, VRst, 1'b0, 0);
    unique case (mode)
      0: begin
        n = (force_n >= 0) ? force_n : int'($urandom_range(0, 40));
        s = g + n;
        for (int k = 1; k <= 8; k++) push(c + k * int'(TD), VEn, 1'b0, 0);
        push(g - 1, VEn, 1'b0, 0);
        last_rt = (n > RMAX) ? RMAX : n;
        push(s + 1, VReact, 1'b1, last_rt);
      end
      1: begin
        int k0;
        k0 = int'($urandom_range(0, 7));
        s = c + k0 * int'(TD) + int'($urandom_range(1, TD - 1));
        for (int k = 1; k <= k0; k++) push(c + k * int'(TD), VEn, 1'b0, 0);
        push(s + 1, VFalse, 1'b1, last_rt);
      end
      2: begin
        s = c + (8 + int'($urandom_range(1, d - 1))) * int'(TD);
        for (int k = 1; k <= 8; k++) push(c + k * int'(TD), VEn, 1'b0, 0);
        push(s + 1, VFalse, 1'b1, last_rt);
      end
      default: begin
        s = c + 3 * int'(TD) + 1;
        for (int k = 1; k <= 3; k++) push(c + k * int'(TD), VEn, 1'b0, 0);
      end
    endcase

    while (cyc < s) begin
      @(negedge clk);
      trigger = (cyc < s) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (cyc == s) begin
        if (mode == 3) rst = 1'b1;
        else stop = 1'b1;
      end
      if (mode == 0 && cyc == g - 1) check("go_before_release", 32'(go), 32'd0);
      if (mode == 0 && cyc == g) check("go_at_release", 32'(go), 32'd1);
    end

    @(negedge clk);
    trigger = 1'b0;
    stop = 1'b0;
    rst = 1'b0;
    if (mode == 3) begin
      last_rt = 0;
      check("mid_reset_go", 32'(go), 32'd0);
      check("mid_reset_fsm_rst", 32'(fsm_rst), 32'd0);
    end
    check("busy_after_end", 32'(busy), 32'd0);
    check("reaction_time_held", 32'(reaction_time), last_rt);
  endtask

  task automatic idle_gap();
    int len;
    len = int'($urandom_range(1, 6));
    repeat (len) begin
      @(negedge clk);
      stop = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    stop = 1'b0;
    check("idle_ignores_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_fsm_rst", 32'(fsm_rst), 32'd0);
    check("reset_fsm_en", 32'(fsm_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_go", 32'(go), 32'd0);
    check("reset_reaction_time", 32'(reaction_time), 32'd0);
    check("reset_reaction_valid", 32'(reaction_valid), 32'd0);
    check("reset_false_start", 32'(false_start), 32'd0);
    rst = 1'b0;

    run(0, 5);
    idle_gap();
    run(2, -1);
    idle_gap();
    run(0, 40);
    idle_gap();
    run(3, -1);
    run(0, -1);
    idle_gap();
    run(1, -1);
    for (int i = 0; i < 20; i++) begin
      idle_gap();
      run(int'($urandom_range(0, 3)), -1);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
